// File: rtl/multi_db_counter.sv
// N-channel input conditioner: 2-flop synchroniser, timer debouncer, rise/fall ticks and
// raw vs debounced rising-edge counters. Define DBC_SATURATE_EN to make counters stick at all-ones.
module multi_db_counter #(
    parameter int N_CH      = 4,
    parameter int DB_CYCLES = 2_000_000,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       sw,
    input  logic [N_CH-1:0]       clr,
    output logic [N_CH-1:0]       db_level,
    output logic [N_CH-1:0]       db_rise,
    output logic [N_CH-1:0]       db_fall,
    output logic [N_CH*CNT_W-1:0] raw_cnt,
    output logic [N_CH*CNT_W-1:0] db_cnt
);

    localparam int               TMR_W    = $clog2(DB_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DB_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_WAIT_HI,
        ST_HIGH,
        ST_WAIT_LO
    } state_t;

    logic [N_CH-1:0]  r_s1;
    logic [N_CH-1:0]  r_s2;
    logic [N_CH-1:0]  r_s2_d;
    logic [N_CH-1:0]  r_rise;
    logic [N_CH-1:0]  r_fall;
    state_t           r_state     [N_CH];
    state_t           w_state_nxt [N_CH];
    logic [TMR_W-1:0] r_timer     [N_CH];
    logic [TMR_W-1:0] w_timer_nxt [N_CH];
    logic [N_CH-1:0]  w_rise_nxt;
    logic [N_CH-1:0]  w_fall_nxt;
    logic [N_CH-1:0]  w_raw_edge;
    logic [CNT_W-1:0] r_raw_cnt   [N_CH];
    logic [CNT_W-1:0] r_db_cnt    [N_CH];

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
`ifdef DBC_SATURATE_EN
        return (&cnt) ? cnt : cnt + CNT_W'(1);
`else
        return cnt + CNT_W'(1);
`endif
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s2_d <= '0;
        end else begin
            r_s1   <= sw;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    assign w_raw_edge = r_s2 & ~r_s2_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_timer_nxt[i] = r_timer[i];
            case (r_state[i])
                ST_LOW: begin
                    if (r_s2[i]) begin
                        w_state_nxt[i] = ST_WAIT_HI;
                        w_timer_nxt[i] = TMR_ONE;
                    end
                end
                ST_WAIT_HI: begin
                    if (!r_s2[i]) begin
                        w_state_nxt[i] = ST_LOW;
                        w_timer_nxt[i] = '0;
                    end else if (r_timer[i] == TMR_LAST) begin
                        w_state_nxt[i] = ST_HIGH;
                        w_timer_nxt[i] = '0;
                    end else begin
                        w_timer_nxt[i] = r_timer[i] + TMR_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!r_s2[i]) begin
                        w_state_nxt[i] = ST_WAIT_LO;
                        w_timer_nxt[i] = TMR_ONE;
                    end
                end
                ST_WAIT_LO: begin
                    if (r_s2[i]) begin
                        w_state_nxt[i] = ST_HIGH;
                        w_timer_nxt[i] = '0;
                    end else if (r_timer[i] == TMR_LAST) begin
                        w_state_nxt[i] = ST_LOW;
                        w_timer_nxt[i] = '0;
                    end else begin
                        w_timer_nxt[i] = r_timer[i] + TMR_ONE;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_LOW;
                    w_timer_nxt[i] = '0;
                end
            endcase
            // Ticks are registered alongside the state so they align with the new level.
            w_rise_nxt[i] = (r_state[i] == ST_WAIT_HI) && (w_state_nxt[i] == ST_HIGH);
            w_fall_nxt[i] = (r_state[i] == ST_WAIT_LO) && (w_state_nxt[i] == ST_LOW);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rise <= '0;
            r_fall <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= ST_LOW;
                r_timer[i] <= '0;
            end
        end else begin
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_timer[i] <= w_timer_nxt[i];
            end
        end
    end

    // Clear wins over any increment in the same cycle; the two counters are otherwise independent.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_raw_cnt[i] <= '0;
                r_db_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (clr[i]) begin
                    r_raw_cnt[i] <= '0;
                    r_db_cnt[i]  <= '0;
                end else begin
                    if (w_raw_edge[i]) begin
                        r_raw_cnt[i] <= cnt_inc(r_raw_cnt[i]);
                    end
                    if (r_rise[i]) begin
                        r_db_cnt[i] <= cnt_inc(r_db_cnt[i]);
                    end
                end
            end
        end
    end

    always_comb begin
        db_level = '0;
        for (int i = 0; i < N_CH; i++) begin
            db_level[i] = (r_state[i] == ST_HIGH) || (r_state[i] == ST_WAIT_LO);
        end
    end

    assign db_rise = r_rise;
    assign db_fall = r_fall;

    for (genvar g = 0; g < N_CH; g++) begin : g_pack
        assign raw_cnt[g*CNT_W +: CNT_W] = r_raw_cnt[g];
        assign db_cnt[g*CNT_W +: CNT_W]  = r_db_cnt[g];
    end

endmodule
